// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_scan block.
//   - FSM state encodings and the matching state enum
//   - mode constants sampled on load
//   - default widths for the select index and the dwell count
package decoder_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int DEF_SEL_W   = 3;
    localparam int DEF_DWELL_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_DIRECT = ST_DIRECT,
        S_SCAN   = ST_SCAN
    } state_t;

endpackage

// File: rtl/decoder_core.sv
// Combinational complement-mapped one-hot decoder.
// Output bit i is high iff en is high and sel == OUT_W-1-i, so an
// all-ones select drives bit 0 and a zero select drives the top bit.
// Ports:
//   sel    : input  [SEL_W-1:0]  index to decode
//   en     : input               gates every output bit
//   onehot : output [OUT_W-1:0]  decoded lines (all zero when en low)
module decoder_core
    import decoder_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic                  en,
    output logic [2**SEL_W-1:0]   onehot
);

    localparam int OUT_W = 2**SEL_W;

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_line
            assign onehot[gi] = en && (sel == SEL_W'(OUT_W - 1 - gi));
        end
    endgenerate

endmodule

// File: rtl/decoder_scan.sv
// Registered complement-mapped N-to-2^N decoder with a load handshake
// and an auto-scan mode that walks every output line with a
// programmable dwell time.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   en      : block enable; low forces IDLE with outputs zeroed
//   load    : one-cycle request sampling sel_in, mode and dwell
//   mode    : 0 = direct (hold one line), 1 = scan (walk lines)
//   sel_in  : start / selected index
//   dwell   : cycles per line minus 1 (scan only)
//   dec_out : registered one-hot output, complement mapped
//   idx_out : index currently driving dec_out
//   busy    : high in DIRECT or SCAN
//   wrap    : one-cycle pulse on the first cycle at index 0 after a wrap
// Build option: define DECODER_SCAN_ONESHOT_EN to make SCAN stop after a
// single pass (the wrap cycle lands in IDLE with outputs cleared).
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = DEF_SEL_W,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   dec_out,
    output logic [SEL_W-1:0]      idx_out,
    output logic                  busy,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

    state_t               state_reg, state_next;
    logic [SEL_W-1:0]     idx_reg, idx_next;
    logic [DWELL_W-1:0]   cnt_reg, cnt_next;
    logic [DWELL_W-1:0]   dwell_reg, dwell_next;
    logic [OUT_W-1:0]     dec_reg, dec_next;
    logic                 busy_reg, busy_next;
    logic                 wrap_reg, wrap_next;

    // Outputs are registered from the *next* state/index so that they
    // change on the same edge as the state itself (one cycle after load).
    decoder_core #(
        .SEL_W (SEL_W)
    ) u_core (
        .sel    (idx_next),
        .en     (state_next != S_IDLE),
        .onehot (dec_next)
    );

    assign busy_next = (state_next != S_IDLE);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        dwell_next = dwell_reg;
        wrap_next  = 1'b0;

        if (!en) begin
            state_next = S_IDLE;
            idx_next   = '0;
            cnt_next   = '0;
        end else if (load) begin
            // Load takes priority over any pending scan advance, and a
            // restart at index 0 is not a wrap.
            state_next = (mode == MODE_SCAN) ? S_SCAN : S_DIRECT;
            idx_next   = sel_in;
            dwell_next = dwell;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                S_SCAN: begin
                    if (cnt_reg == dwell_reg) begin
                        cnt_next = '0;
                        idx_next = idx_reg + SEL_W'(1);
                        if (idx_reg == IDX_MAX) begin
                            wrap_next = 1'b1;
`ifdef DECODER_SCAN_ONESHOT_EN
                            state_next = S_IDLE;
`endif
                        end
                    end else begin
                        cnt_next = cnt_reg + DWELL_W'(1);
                    end
                end
                S_DIRECT: begin
                    state_next = S_DIRECT;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            dwell_reg <= '0;
            dec_reg   <= '0;
            busy_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            dwell_reg <= dwell_next;
            dec_reg   <= dec_next;
            busy_reg  <= busy_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign dec_out = dec_reg;
    assign idx_out = idx_reg;
    assign busy    = busy_reg;
    assign wrap    = wrap_reg;

endmodule

// File: tb/tb_decoder_scan.sv
module tb_decoder_scan;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       load;
    logic       mode;
    logic [2:0] sel_in;
    logic [3:0] dwell;
    logic [7:0] dec_out;
    logic [2:0] idx_out;
    logic       busy;
    logic       wrap;

    int tests;
    int failed;

    decoder_scan #(
        .SEL_W   (3),
        .DWELL_W (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .mode    (mode),
        .sel_in  (sel_in),
        .dwell   (dwell),
        .dec_out (dec_out),
        .idx_out (idx_out),
        .busy    (busy),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic m, input logic [2:0] s, input logic [3:0] d);
        mode   = m;
        sel_in = s;
        dwell  = d;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load   = 1'b0;
        $display("[TB] load mode=%0d sel=%0d dwell=%0d -> idx=%0d dec=%h busy=%0d wrap=%0d",
                 m, s, d, idx_out, dec_out, busy, wrap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; mode = 1'b0; sel_in = '0; dwell = '0;
        step();
        step();
        tests++; if (dec_out !== 8'h00) begin failed++; $display("FAIL reset_dec: got %h expected %h", dec_out, 8'h00); end
        tests++; if (idx_out !== 3'd0)  begin failed++; $display("FAIL reset_idx: got %0d expected %0d", idx_out, 0); end
        tests++; if (busy !== 1'b0)     begin failed++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
        tests++; if (wrap !== 1'b0)     begin failed++; $display("FAIL reset_wrap: got %b expected %b", wrap, 1'b0); end
        rst_n = 1'b1;
        step();
        tests++; if (busy !== 1'b0)     begin failed++; $display("FAIL idle_busy: got %b expected %b", busy, 1'b0); end
    endtask

    task automatic test_direct();
        en = 1'b1;
        do_load(1'b0, 3'd7, 4'd0);
        tests++; if (dec_out !== 8'h01) begin failed++; $display("FAIL direct7_dec: got %h expected %h", dec_out, 8'h01); end
        tests++; if (busy !== 1'b1)     begin failed++; $display("FAIL direct7_busy: got %b expected %b", busy, 1'b1); end
        tests++; if (idx_out !== 3'd7)  begin failed++; $display("FAIL direct7_idx: got %0d expected %0d", idx_out, 7); end
        step();
        step();
        tests++; if (dec_out !== 8'h01) begin failed++; $display("FAIL direct7_hold: got %h expected %h", dec_out, 8'h01); end
        do_load(1'b0, 3'd0, 4'd0);
        tests++; if (dec_out !== 8'h80) begin failed++; $display("FAIL direct0_dec: got %h expected %h", dec_out, 8'h80); end
        tests++; if (wrap !== 1'b0)     begin failed++; $display("FAIL direct0_wrap: got %b expected %b", wrap, 1'b0); end
        do_load(1'b0, 3'd5, 4'd0);
        tests++; if (dec_out !== 8'h04) begin failed++; $display("FAIL direct5_dec: got %h expected %h", dec_out, 8'h04); end
    endtask

    task automatic test_scan();
        logic [2:0] exp_idx [0:9];
        logic [7:0] exp_dec [0:9];
        logic       exp_wrap[0:9];
        logic       exp_busy[0:9];
        // hand-written: idx 6 x3, 7 x3, then 0 (wrap), 0, 0, 1
        exp_idx  = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd1};
        exp_dec  = '{8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h40};
        exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef DECODER_SCAN_ONESHOT_EN
        exp_idx[9]  = 3'd0;
        exp_dec[6]  = 8'h00; exp_dec[7] = 8'h00; exp_dec[8] = 8'h00; exp_dec[9] = 8'h00;
        exp_busy[6] = 1'b0;  exp_busy[7] = 1'b0; exp_busy[8] = 1'b0; exp_busy[9] = 1'b0;
`endif
        en = 1'b1;
        do_load(1'b1, 3'd6, 4'd2);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            tests++; if (idx_out !== exp_idx[k])  begin failed++; $display("FAIL scan_idx[%0d]: got %0d expected %0d", k, idx_out, exp_idx[k]); end
            tests++; if (dec_out !== exp_dec[k])  begin failed++; $display("FAIL scan_dec[%0d]: got %h expected %h", k, dec_out, exp_dec[k]); end
            tests++; if (wrap !== exp_wrap[k])    begin failed++; $display("FAIL scan_wrap[%0d]: got %b expected %b", k, wrap, exp_wrap[k]); end
            tests++; if (busy !== exp_busy[k])    begin failed++; $display("FAIL scan_busy[%0d]: got %b expected %b", k, busy, exp_busy[k]); end
        end
    endtask

    task automatic test_oneshot();
        en = 1'b1;
        do_load(1'b1, 3'd7, 4'd0);
        tests++; if (dec_out !== 8'h01) begin failed++; $display("FAIL os_start_dec: got %h expected %h", dec_out, 8'h01); end
        step();
        tests++; if (wrap !== 1'b1)     begin failed++; $display("FAIL os_wrap: got %b expected %b", wrap, 1'b1); end
        tests++; if (idx_out !== 3'd0)  begin failed++; $display("FAIL os_idx: got %0d expected %0d", idx_out, 0); end
`ifdef DECODER_SCAN_ONESHOT_EN
        tests++; if (busy !== 1'b0)     begin failed++; $display("FAIL os_busy: got %b expected %b", busy, 1'b0); end
        tests++; if (dec_out !== 8'h00) begin failed++; $display("FAIL os_dec: got %h expected %h", dec_out, 8'h00); end
        step();
        tests++; if (idx_out !== 3'd0)  begin failed++; $display("FAIL os_hold_idx: got %0d expected %0d", idx_out, 0); end
        tests++; if (wrap !== 1'b0)     begin failed++; $display("FAIL os_wrap_end: got %b expected %b", wrap, 1'b0); end
`else
        tests++; if (busy !== 1'b1)     begin failed++; $display("FAIL os_busy: got %b expected %b", busy, 1'b1); end
        tests++; if (dec_out !== 8'h80) begin failed++; $display("FAIL os_dec: got %h expected %h", dec_out, 8'h80); end
        step();
        tests++; if (idx_out !== 3'd1)  begin failed++; $display("FAIL os_next_idx: got %0d expected %0d", idx_out, 1); end
        tests++; if (wrap !== 1'b0)     begin failed++; $display("FAIL os_wrap_end: got %b expected %b", wrap, 1'b0); end
        step();
        tests++; if (idx_out !== 3'd2)  begin failed++; $display("FAIL os_next2_idx: got %0d expected %0d", idx_out, 2); end
`endif
    endtask

    task automatic test_preempt();
        en = 1'b1;
        // dwell 0: the cycle at idx 4 has an advance pending, load must win
        do_load(1'b1, 3'd3, 4'd0);
        step();
        tests++; if (idx_out !== 3'd4)  begin failed++; $display("FAIL pre_idx4: got %0d expected %0d", idx_out, 4); end
        do_load(1'b0, 3'd1, 4'd0);
        tests++; if (idx_out !== 3'd1)  begin failed++; $display("FAIL pre_idx: got %0d expected %0d", idx_out, 1); end
        tests++; if (dec_out !== 8'h40) begin failed++; $display("FAIL pre_dec: got %h expected %h", dec_out, 8'h40); end
        tests++; if (wrap !== 1'b0)     begin failed++; $display("FAIL pre_wrap: got %b expected %b", wrap, 1'b0); end
        step();
        step();
        tests++; if (idx_out !== 3'd1)  begin failed++; $display("FAIL pre_direct_hold: got %0d expected %0d", idx_out, 1); end
        // reload to index 0 at the wrap point: no wrap pulse
        do_load(1'b1, 3'd6, 4'd0);
        step();
        tests++; if (idx_out !== 3'd7)  begin failed++; $display("FAIL pre_at7: got %0d expected %0d", idx_out, 7); end
        do_load(1'b1, 3'd0, 4'd0);
        tests++; if (wrap !== 1'b0)     begin failed++; $display("FAIL pre_load0_wrap: got %b expected %b", wrap, 1'b0); end
        tests++; if (dec_out !== 8'h80) begin failed++; $display("FAIL pre_load0_dec: got %h expected %h", dec_out, 8'h80); end
        step();
        tests++; if (idx_out !== 3'd1)  begin failed++; $display("FAIL pre_load0_next: got %0d expected %0d", idx_out, 1); end
    endtask

    task automatic test_dwell_max();
        en = 1'b1;
        do_load(1'b1, 3'd0, 4'd15);
        for (int k = 1; k < 16; k++) step();
        tests++; if (idx_out !== 3'd0)  begin failed++; $display("FAIL dwell15_last: got %0d expected %0d", idx_out, 0); end
        step();
        tests++; if (idx_out !== 3'd1)  begin failed++; $display("FAIL dwell15_adv: got %0d expected %0d", idx_out, 1); end
        tests++; if (dec_out !== 8'h40) begin failed++; $display("FAIL dwell15_dec: got %h expected %h", dec_out, 8'h40); end
    endtask

    task automatic test_enable_drop();
        en = 1'b1;
        do_load(1'b1, 3'd2, 4'd1);
        step();
        en = 1'b0;
        step();
        tests++; if (dec_out !== 8'h00) begin failed++; $display("FAIL endrop_dec: got %h expected %h", dec_out, 8'h00); end
        tests++; if (busy !== 1'b0)     begin failed++; $display("FAIL endrop_busy: got %b expected %b", busy, 1'b0); end
        tests++; if (idx_out !== 3'd0)  begin failed++; $display("FAIL endrop_idx: got %0d expected %0d", idx_out, 0); end
        mode = 1'b0; sel_in = 3'd5; load = 1'b1;
        step();
        load = 1'b0;
        tests++; if (busy !== 1'b0)     begin failed++; $display("FAIL enload_busy: got %b expected %b", busy, 1'b0); end
        tests++; if (dec_out !== 8'h00) begin failed++; $display("FAIL enload_dec: got %h expected %h", dec_out, 8'h00); end
        en = 1'b1;
        step();
        tests++; if (busy !== 1'b0)     begin failed++; $display("FAIL enback_busy: got %b expected %b", busy, 1'b0); end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        do_load(1'b1, 3'd5, 4'd0);
        step();
        tests++; if (busy !== 1'b1)     begin failed++; $display("FAIL ar_pre_busy: got %b expected %b", busy, 1'b1); end
        rst_n = 1'b0;
        #2;
        tests++; if (dec_out !== 8'h00) begin failed++; $display("FAIL ar_dec: got %h expected %h", dec_out, 8'h00); end
        tests++; if (busy !== 1'b0)     begin failed++; $display("FAIL ar_busy: got %b expected %b", busy, 1'b0); end
        tests++; if (idx_out !== 3'd0)  begin failed++; $display("FAIL ar_idx: got %0d expected %0d", idx_out, 0); end
        step();
        rst_n = 1'b1;
        step();
        tests++; if (busy !== 1'b0)     begin failed++; $display("FAIL ar_after_busy: got %b expected %b", busy, 1'b0); end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_direct();
        test_scan();
        test_oneshot();
        test_preempt();
        test_dwell_max();
        test_enable_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
